// File: rtl/cache_pkg.sv
// Shared cache definitions: way geometry, replacement FSM states and the
// 7-bit tree pseudo-LRU victim/touch helpers.
package cache_pkg;

    localparam int WAYS   = 8;
    localparam int WAY_W  = 3;
    localparam int PLRU_W = 7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ALLOC = 1'b1
    } repl_state_t;

    // A tree bit of 0 steers the victim walk toward the lower half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] tree);
        logic       w2;
        logic       w1;
        logic       w0;
        logic [2:0] idx;
        w2  = tree[0];
        w1  = w2 ? tree[2] : tree[1];
        idx = 3'd3 + {1'b0, w2, w1};
        w0  = tree[idx];
        return {w2, w1, w0};
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] tree,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] t;
        logic [2:0]        idx1;
        logic [2:0]        idx2;
        t       = tree;
        idx1    = 3'd1 + {2'b00, way[2]};
        idx2    = 3'd3 + {1'b0, way[2:1]};
        t[0]    = ~way[2];
        t[idx1] = ~way[1];
        t[idx2] = ~way[0];
        return t;
    endfunction

endpackage

// File: rtl/decoder3to8.sv
// Enable-gated 3-to-8 one-hot decoder; all outputs low when en is low.
module decoder3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign y[gi] = en && (sel == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/way_replace_ctrl.sv
// 8-way tree-PLRU replacement controller with miss/fill allocation FSM.
// Optional hit/miss statistics counters are enabled by defining REPL_STATS_EN.
module way_replace_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             access_valid,
    input  logic [IDX_W-1:0] access_set,
    input  logic             access_hit,
    input  logic [2:0]       access_hit_way,
    input  logic             fill_done,
    output logic             access_ready,
    output logic             victim_valid,
    output logic [2:0]       victim_way,
    output logic [7:0]       victim_sel
`ifdef REPL_STATS_EN
    ,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
`endif
);

    repl_state_t       state_reg, state_next;
    logic [IDX_W-1:0]  set_reg, set_next;
    logic [WAY_W-1:0]  victim_way_reg, victim_way_next;

    logic                              wr_en;
    logic [IDX_W-1:0]                  wr_set;
    logic [PLRU_W-1:0]                 wr_tree;
    logic [NUM_SETS-1:0][PLRU_W-1:0]   tree_bus;
    logic [PLRU_W-1:0]                 cur_tree;
    logic [PLRU_W-1:0]                 lat_tree;

    // Trees live in flops rather than RAM so that reset clears every set at once.
    generate
        for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
            logic [PLRU_W-1:0] tree_reg;
            always_ff @(posedge clk) begin
                if (!reset_n)
                    tree_reg <= '0;
                else if (wr_en && (wr_set == IDX_W'(gi)))
                    tree_reg <= wr_tree;
            end
            assign tree_bus[gi] = tree_reg;
        end
    endgenerate

    assign cur_tree = tree_bus[access_set];
    assign lat_tree = tree_bus[set_reg];

    always_comb begin
        state_next      = state_reg;
        set_next        = set_reg;
        victim_way_next = victim_way_reg;
        wr_en           = 1'b0;
        wr_set          = access_set;
        wr_tree         = cur_tree;
        case (state_reg)
            IDLE: begin
                if (access_valid) begin
                    if (access_hit) begin
                        wr_en   = 1'b1;
                        wr_tree = plru_touch(cur_tree, access_hit_way);
                    end else begin
                        set_next        = access_set;
                        victim_way_next = plru_victim(cur_tree);
                        state_next      = ALLOC;
                    end
                end
            end
            ALLOC: begin
                if (fill_done) begin
                    wr_en      = 1'b1;
                    wr_set     = set_reg;
                    wr_tree    = plru_touch(lat_tree, victim_way_reg);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            set_reg        <= '0;
            victim_way_reg <= '0;
        end else begin
            state_reg      <= state_next;
            set_reg        <= set_next;
            victim_way_reg <= victim_way_next;
        end
    end

    assign access_ready = (state_reg == IDLE);
    assign victim_valid = (state_reg == ALLOC);
    assign victim_way   = victim_way_reg;

    decoder3to8 u_victim_dec (
        .en  (victim_valid),
        .sel (victim_way_reg),
        .y   (victim_sel)
    );

`ifdef REPL_STATS_EN
    logic        hit_acc;
    logic        miss_acc;
    logic [15:0] hit_count_reg;
    logic [15:0] miss_count_reg;

    assign hit_acc  = (state_reg == IDLE) && access_valid && access_hit;
    assign miss_acc = (state_reg == IDLE) && access_valid && !access_hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit_acc && (hit_count_reg != 16'hFFFF))
                hit_count_reg <= hit_count_reg + 16'd1;
            if (miss_acc && (miss_count_reg != 16'hFFFF))
                miss_count_reg <= miss_count_reg + 16'd1;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule
